// File: rtl/cosim_scoreboard_if.sv
// Handshake and result bundle for cosim_scoreboard.
//   gold_valid/gold_data/gold_ready : golden stream, valid/ready handshake
//   dut_valid/dut_data/dut_ready    : DUT stream, valid/ready handshake
//   match_cnt/mismatch_cnt          : saturating pair counters
//   err_flag, first_err_*           : sticky first-mismatch capture
//   timeout_flag                    : sticky one-sided stall indication
// master = stream producer / result observer, slave = the scoreboard.
// W and CNT_W must match the parameters of the attached scoreboard.
interface cosim_scoreboard_if #(
    parameter int unsigned W     = 16,
    parameter int unsigned CNT_W = 16
);
    logic             gold_valid;
    logic [W-1:0]     gold_data;
    logic             gold_ready;
    logic             dut_valid;
    logic [W-1:0]     dut_data;
    logic             dut_ready;
    logic [CNT_W-1:0] match_cnt;
    logic [CNT_W-1:0] mismatch_cnt;
    logic             err_flag;
    logic [W-1:0]     first_err_gold;
    logic [W-1:0]     first_err_dut;
    logic [CNT_W-1:0] first_err_idx;
    logic             timeout_flag;

    modport master (
        output gold_valid, gold_data, dut_valid, dut_data,
        input  gold_ready, dut_ready, match_cnt, mismatch_cnt, err_flag,
        input  first_err_gold, first_err_dut, first_err_idx, timeout_flag
    );

    modport slave (
        input  gold_valid, gold_data, dut_valid, dut_data,
        output gold_ready, dut_ready, match_cnt, mismatch_cnt, err_flag,
        output first_err_gold, first_err_dut, first_err_idx, timeout_flag
    );
endinterface

// File: rtl/cosim_scoreboard.sv
// In-order co-simulation scoreboard. Buffers a golden and a DUT stream in
// separate DEPTH-entry FIFOs, compares heads pairwise one per cycle, keeps
// saturating match/mismatch counters, captures the first mismatch and flags
// a stall where only one side has data for TIMEOUT cycles.
// Ports:
//   CLK    : clock, rising edge
//   _RESET : asynchronous active-low reset
//   clear  : synchronous clear of FIFOs, counters and flags (ready stays high)
//   sb     : cosim_scoreboard_if.slave, streams in and results out
module cosim_scoreboard #(
    parameter int unsigned W       = 16,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned TIMEOUT = 256
) (
    input  logic              CLK,
    input  logic              _RESET,
    input  logic              clear,
    cosim_scoreboard_if.slave sb
);
    localparam int unsigned AW     = $clog2(DEPTH);
    localparam int unsigned WAIT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT);

    logic [W-1:0]      r_gold_mem [DEPTH];
    logic [W-1:0]      r_dut_mem  [DEPTH];
    // Extra MSB on each pointer separates full from empty.
    logic [AW:0]       r_gold_wr, r_gold_rd, r_dut_wr, r_dut_rd;
    logic              r_rdy_en;
    logic [CNT_W-1:0]  r_match_cnt, r_mismatch_cnt, r_cmp_idx, r_first_err_idx;
    logic              r_err_flag, r_timeout_flag;
    logic [W-1:0]      r_first_err_gold, r_first_err_dut;
    logic [WAIT_W-1:0] r_wait_cnt;

    logic              w_gold_empty, w_gold_full, w_dut_empty, w_dut_full;
    logic              w_gold_push, w_dut_push, w_cmp, w_one_side, w_equal;
    logic              w_timeout_hit;
    logic [W-1:0]      w_gold_head, w_dut_head;
    logic [WAIT_W-1:0] w_wait_nxt;

    assign w_gold_empty = (r_gold_wr == r_gold_rd);
    assign w_dut_empty  = (r_dut_wr == r_dut_rd);
    assign w_gold_full  = (r_gold_wr[AW] != r_gold_rd[AW]) &&
                          (r_gold_wr[AW-1:0] == r_gold_rd[AW-1:0]);
    assign w_dut_full   = (r_dut_wr[AW] != r_dut_rd[AW]) &&
                          (r_dut_wr[AW-1:0] == r_dut_rd[AW-1:0]);

    // r_rdy_en holds both readies low through reset and the first edge after.
    assign sb.gold_ready = r_rdy_en & ~w_gold_full;
    assign sb.dut_ready  = r_rdy_en & ~w_dut_full;
    assign w_gold_push   = sb.gold_valid & sb.gold_ready;
    assign w_dut_push    = sb.dut_valid & sb.dut_ready;

    assign w_gold_head = r_gold_mem[r_gold_rd[AW-1:0]];
    assign w_dut_head  = r_dut_mem[r_dut_rd[AW-1:0]];
    assign w_cmp       = ~w_gold_empty & ~w_dut_empty;
    assign w_one_side  = w_gold_empty ^ w_dut_empty;
    assign w_equal     = (w_gold_head == w_dut_head);

    // Stall counter: counts while exactly one side holds data, holds at TIMEOUT.
    always_comb begin
        w_wait_nxt = r_wait_cnt;
        if (!w_one_side) begin
            w_wait_nxt = '0;
        end else if (r_wait_cnt != WAIT_MAX) begin
            w_wait_nxt = r_wait_cnt + 1'b1;
        end
        w_timeout_hit = (TIMEOUT != 0) && (w_wait_nxt == WAIT_MAX);
    end

    // Storage carries no reset; entries are only read while marked valid.
    always_ff @(posedge CLK) begin
        if (w_gold_push && !clear) r_gold_mem[r_gold_wr[AW-1:0]] <= sb.gold_data;
        if (w_dut_push && !clear)  r_dut_mem[r_dut_wr[AW-1:0]]   <= sb.dut_data;
    end

    always_ff @(posedge CLK or negedge _RESET) begin
        if (!_RESET) begin
            r_rdy_en         <= 1'b0;
            r_gold_wr        <= '0;
            r_gold_rd        <= '0;
            r_dut_wr         <= '0;
            r_dut_rd         <= '0;
            r_match_cnt      <= '0;
            r_mismatch_cnt   <= '0;
            r_cmp_idx        <= '0;
            r_err_flag       <= 1'b0;
            r_first_err_gold <= '0;
            r_first_err_dut  <= '0;
            r_first_err_idx  <= '0;
            r_timeout_flag   <= 1'b0;
            r_wait_cnt       <= '0;
        end else if (clear) begin
            // Same-edge pushes and compares are dropped.
            r_rdy_en         <= 1'b1;
            r_gold_wr        <= '0;
            r_gold_rd        <= '0;
            r_dut_wr         <= '0;
            r_dut_rd         <= '0;
            r_match_cnt      <= '0;
            r_mismatch_cnt   <= '0;
            r_cmp_idx        <= '0;
            r_err_flag       <= 1'b0;
            r_first_err_gold <= '0;
            r_first_err_dut  <= '0;
            r_first_err_idx  <= '0;
            r_timeout_flag   <= 1'b0;
            r_wait_cnt       <= '0;
        end else begin
            r_rdy_en   <= 1'b1;
            r_wait_cnt <= w_wait_nxt;
            if (w_timeout_hit) r_timeout_flag <= 1'b1;
            if (w_gold_push) r_gold_wr <= r_gold_wr + 1'b1;
            if (w_dut_push)  r_dut_wr  <= r_dut_wr + 1'b1;
            if (w_cmp) begin
                r_gold_rd <= r_gold_rd + 1'b1;
                r_dut_rd  <= r_dut_rd + 1'b1;
                r_cmp_idx <= r_cmp_idx + 1'b1;
                if (w_equal) begin
                    if (r_match_cnt != '1) r_match_cnt <= r_match_cnt + 1'b1;
                end else begin
                    if (r_mismatch_cnt != '1) r_mismatch_cnt <= r_mismatch_cnt + 1'b1;
                    if (!r_err_flag) begin
                        r_err_flag       <= 1'b1;
                        r_first_err_gold <= w_gold_head;
                        r_first_err_dut  <= w_dut_head;
                        r_first_err_idx  <= r_cmp_idx;
                    end
                end
            end
        end
    end

    assign sb.match_cnt      = r_match_cnt;
    assign sb.mismatch_cnt   = r_mismatch_cnt;
    assign sb.err_flag       = r_err_flag;
    assign sb.first_err_gold = r_first_err_gold;
    assign sb.first_err_dut  = r_first_err_dut;
    assign sb.first_err_idx  = r_first_err_idx;
    assign sb.timeout_flag   = r_timeout_flag;
endmodule

// File: doc/cosim_scoreboard.md
Name: cosim_scoreboard

Overview:
- Clocked, synthesizable in-order co-simulation scoreboard. Generalises the testbench checker that compares the golden CSP model against the RTL model.
- Accepts one golden stream and one DUT stream over valid/ready handshakes, buffering each in its own DEPTH-entry FIFO, so either side may run ahead.
- Compares entries pairwise in arrival order and keeps saturating match/mismatch counters.
- Captures the first mismatch, and flags a timeout when one side stalls.
- Sits at the boundary between the handshake-to-clock adapters and the NoC cosim harness.

Parameters:
W, 16, data width of both streams
DEPTH, 4, per-side FIFO depth; power of two, >=2
CNT_W, 16, width of counters and compare index
TIMEOUT, 256, cycles one-sided data may wait before timeout_flag is set; 0 disables the timeout

Ports:
CLK  in  1  clock, all state updates on rising edge
_RESET  in  1  asynchronous, active-low reset
clear  in  1  synchronous clear of FIFOs, counters and flags
gold_valid  in  1  golden word offered
gold_data  in  W  golden word
gold_ready  out  1  golden FIFO can accept
dut_valid  in  1  DUT word offered
dut_data  in  W  DUT word
dut_ready  out  1  DUT FIFO can accept
match_cnt  out  CNT_W  number of equal pairs, saturating
mismatch_cnt  out  CNT_W  number of unequal pairs, saturating
err_flag  out  1  sticky: at least one mismatch seen
first_err_gold  out  W  golden word of first mismatch
first_err_dut  out  W  DUT word of first mismatch
first_err_idx  out  CNT_W  compare index (0-based) of first mismatch
timeout_flag  out  1  sticky: one-sided wait reached TIMEOUT

Behaviour:
- Reset (_RESET=0, asynchronous): FIFOs empty; all counters, flags, first_err_* and compare index are 0.
- During reset, gold_ready and dut_ready are 0. Both rise in the first cycle after _RESET deasserts.
- Push: gold_ready = !gold_full and dut_ready = !dut_full, both registered-state based. A word is written at the edge where valid && ready.
- Data must be held while valid && !ready. Valid while not ready is legal and accepted later.
- Compare: at any edge where both FIFOs are non-empty, pop one head from each and compare.
  - If equal, match_cnt += 1.
  - Otherwise mismatch_cnt += 1, and if err_flag==0: set err_flag; capture both heads into first_err_gold/first_err_dut; capture the current index into first_err_idx.
  - The compare index increments on every compare and wraps modulo 2^CNT_W.
- Latency: a pair pushed at edge t is compared at edge t+1, and the result is visible on outputs after edge t+1. Throughput is one compare per cycle.
- Counters saturate at 2^CNT_W-1 and do not wrap.
- Full FIFO: push and pop in the same cycle are allowed only when not full, since ready is low when full. The pointers use an extra wrap bit to distinguish full from empty.
- Timeout:
  - wait_cnt increments each cycle where exactly one FIFO is non-empty and no compare occurs.
  - wait_cnt clears when both FIFOs are empty or a compare occurs.
  - When wait_cnt reaches TIMEOUT (TIMEOUT>0), timeout_flag sets and stays set. wait_cnt holds at TIMEOUT.
- clear=1 at an edge acts like reset, except ready stays high. The clear takes priority over a same-edge push/compare, and those operations are discarded.
- err_flag, first_err_* and timeout_flag change only through reset, clear or their set conditions.

Test Plan:
- Reset then 10 identical pairs 1..10 pushed simultaneously -> match_cnt=10, mismatch_cnt=0, err_flag=0, each result visible 1 cycle after push.
- Golden 5,6,7; DUT 5,9,7 -> match_cnt=2, mismatch_cnt=1, err_flag=1, first_err_gold=6, first_err_dut=9, first_err_idx=1. A later mismatch 8 vs 3 leaves first_err_* unchanged.
- DEPTH=4, push 4 golden words with no DUT words -> gold_ready=0 after the 4th. Then push 4 DUT words -> 4 compares on consecutive cycles, gold_ready high again.
- TIMEOUT=8: one golden word, DUT idle -> timeout_flag=1 exactly 8 cycles after the word enters the FIFO. With TIMEOUT=0 it never sets.
- CNT_W=4: 20 matching pairs -> match_cnt=15 (saturated), compare index wrapped.
- _RESET pulsed low mid-stream with FIFOs half full and err_flag=1 -> all outputs 0 immediately, readies 0 until release. clear=1 with a simultaneous push -> FIFOs empty next cycle.
